// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: funct codes, ALUOp codes,
// forwarding selects and the mult/div FSM state encoding.
package ex_pkg;

    localparam int XLEN      = 32;
    localparam int MD_CYCLES = 32;

    // R-type funct codes
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    // ALUOp codes
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_SLT   = 2'b11;

    // Forwarding selects (2'b11 falls back to the register value)
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    function automatic logic is_muldiv(input logic [5:0] funct);
        return (funct == F_MULT) || (funct == F_MULTU) ||
               (funct == F_DIV)  || (funct == F_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit with the HI/LO registers.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   start_i             mult/div instruction present in EX
//   abort_i             squash request (EX flush)
//   is_div_i            1 = divide, 0 = multiply
//   is_signed_i         1 = signed operation
//   a_i, b_i            forwarded operands (dividend/divisor for div)
//   stall_o             pipeline hold while the unit is busy
//   done_o              final cycle of an operation (EX/MEM takes a bubble)
//   hi_o, lo_o          committed HI/LO
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting; a start latches operand magnitudes and stalls
// RUN     | one shift-add / restoring-divide step per cycle
// DONE    | HI/LO already committed; stall released, bubble issued
module ex_muldiv
    import ex_pkg::*;
#(
    parameter int XLEN      = ex_pkg::XLEN,
    parameter int MD_CYCLES = ex_pkg::MD_CYCLES
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            is_div_i,
    input  logic            is_signed_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int CW = $clog2(MD_CYCLES);

    md_state_e       state_q, state_d;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] mcand_q;     // multiplicand or divisor magnitude
    logic [XLEN-1:0] acc_hi_q;    // partial product high half / remainder
    logic [XLEN-1:0] acc_lo_q;    // multiplier / dividend -> quotient
    logic            neg_q;       // negate product or quotient
    logic            rem_neg_q;   // remainder takes dividend sign
    logic            is_div_q;
    logic            div_zero_q;
    logic [XLEN-1:0] hi_q, lo_q;

    logic            last_step;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [2*XLEN-1:0] prod_raw, prod_fin;
    logic [XLEN-1:0] fin_hi, fin_lo;
    logic [XLEN-1:0] a_abs, b_abs;

    assign a_abs = (is_signed_i && a_i[XLEN-1]) ? -a_i : a_i;
    assign b_abs = (is_signed_i && b_i[XLEN-1]) ? -b_i : b_i;

    assign last_step = (count_q == CW'(MD_CYCLES - 1));

    // One iteration of either algorithm on the current accumulators.
    always_comb begin
        add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        if (is_div_q) begin
            // Borrow out of the trial subtraction means restore.
            if (!div_diff[XLEN]) begin
                step_hi = div_diff[XLEN-1:0];
                step_lo = {acc_lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_shift[XLEN-1:0];
                step_lo = {acc_lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = add_sum[XLEN:1];
            step_lo = {add_sum[0], acc_lo_q[XLEN-1:1]};
        end
    end

    // Sign correction applied on the last step's output.
    always_comb begin
        prod_raw = {step_hi, step_lo};
        prod_fin = neg_q ? -prod_raw : prod_raw;
        if (is_div_q) begin
            fin_lo = div_zero_q ? '1 : (neg_q ? -step_lo : step_lo);
            fin_hi = rem_neg_q ? -step_hi : step_hi;
        end else begin
            fin_lo = prod_fin[XLEN-1:0];
            fin_hi = prod_fin[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = MD_RUN;
                    stall_o = 1'b1;
                end
            end
            MD_RUN: begin
                if (abort_i) begin
                    state_d = MD_IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (last_step) state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                done_o  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        // The pipeline must never see a hold while reset is asserted.
        if (rst_i) stall_o = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= MD_IDLE;
            count_q    <= '0;
            mcand_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == MD_IDLE && start_i && !abort_i) begin
                count_q    <= '0;
                mcand_q    <= is_div_i ? b_abs : a_abs;
                acc_lo_q   <= is_div_i ? a_abs : b_abs;
                acc_hi_q   <= '0;
                neg_q      <= is_signed_i && (a_i[XLEN-1] ^ b_i[XLEN-1]);
                rem_neg_q  <= is_signed_i && a_i[XLEN-1];
                is_div_q   <= is_div_i;
                div_zero_q <= (b_i == '0);
            end else if (state_q == MD_RUN && !abort_i) begin
                count_q  <= count_q + 1'b1;
                acc_hi_q <= step_hi;
                acc_lo_q <= step_lo;
                if (last_step) begin
                    hi_q <= fin_hi;
                    lo_q <= fin_lo;
                end
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, destination select, mult/div
// sequencing and the EX/MEM pipeline register.
// Ports:
//   CLK, RST                      clock, async active-high reset
//   control_wb/MemRead/MemWrite   control from ID/EX, passed to EX/MEM
//   ALUOp, ALUSrc, RegDst         EX control
//   read_data_1/2, sign_ext_imm   operands; imm[10:6]=shamt, imm[5:0]=funct
//   rt, rd                        destination candidates
//   forward_a/b, mem_fwd_data, wb_fwd_data   forwarding selects and data
//   ex_flush                      squash the instruction in EX
//   ex_stall                      hold upstream stages (combinational)
//   ex_*                          EX/MEM register outputs
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN      = ex_pkg::XLEN,
    parameter int MD_CYCLES = ex_pkg::MD_CYCLES
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [1:0]      control_wb,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [1:0]      ALUOp,
    input  logic            ALUSrc,
    input  logic            RegDst,
    input  logic [XLEN-1:0] read_data_1,
    input  logic [XLEN-1:0] read_data_2,
    input  logic [XLEN-1:0] sign_ext_imm,
    input  logic [4:0]      rt,
    input  logic [4:0]      rd,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            ex_flush,
    output logic            ex_stall,
    output logic [1:0]      ex_control_wb,
    output logic            ex_MemRead,
    output logic            ex_MemWrite,
    output logic [XLEN-1:0] ex_address,
    output logic [XLEN-1:0] ex_writeData,
    output logic [4:0]      ex_write_register
);

    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_result;
    logic [XLEN-1:0] hi, lo;
    logic [5:0]      funct;
    logic [4:0]      shamt;
    logic [4:0]      write_register;
    logic            md_trigger, md_stall, md_done, bubble;

    logic [1:0]      ctrl_wb_q;
    logic            mem_read_q, mem_write_q;
    logic [XLEN-1:0] address_q, write_data_q;
    logic [4:0]      write_reg_q;

    assign funct = sign_ext_imm[5:0];
    assign shamt = sign_ext_imm[10:6];

    always_comb begin
        case (forward_a)
            FWD_MEM: op_a = mem_fwd_data;
            FWD_WB:  op_a = wb_fwd_data;
            default: op_a = read_data_1;
        endcase
        case (forward_b)
            FWD_MEM: fwd_b = mem_fwd_data;
            FWD_WB:  fwd_b = wb_fwd_data;
            default: fwd_b = read_data_2;
        endcase
        op_b = ALUSrc ? sign_ext_imm : fwd_b;
    end

    always_comb begin
        alu_result = '0;
        case (ALUOp)
            ALU_ADD: alu_result = op_a + op_b;
            ALU_SUB: alu_result = op_a - op_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: alu_result = op_a + op_b;
                    F_SUB, F_SUBU: alu_result = op_a - op_b;
                    F_AND:  alu_result = op_a & op_b;
                    F_OR:   alu_result = op_a | op_b;
                    F_XOR:  alu_result = op_a ^ op_b;
                    F_NOR:  alu_result = ~(op_a | op_b);
                    F_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    F_SLTU: alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
                    F_SLL:  alu_result = op_b << shamt;
                    F_SRL:  alu_result = op_b >> shamt;
                    F_SRA:  alu_result = $signed(op_b) >>> shamt;
                    F_MFHI: alu_result = hi;
                    F_MFLO: alu_result = lo;
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

    assign write_register = RegDst ? rd : rt;
    assign md_trigger     = (ALUOp == ALU_RTYPE) && is_muldiv(funct);

    // funct[1] separates div from mult, funct[0] marks the unsigned forms.
    ex_muldiv #(
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk_i       (CLK),
        .rst_i       (RST),
        .start_i     (md_trigger),
        .abort_i     (ex_flush),
        .is_div_i    (funct[1]),
        .is_signed_i (~funct[0]),
        .a_i         (op_a),
        .b_i         (fwd_b),
        .stall_o     (md_stall),
        .done_o      (md_done),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    assign ex_stall = md_stall;

    // A mult/div never writes a GPR, so its trigger cycle is also a bubble.
    assign bubble = ex_flush || md_stall || md_done || md_trigger;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl_wb_q    <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            write_reg_q  <= '0;
        end else if (bubble) begin
            ctrl_wb_q    <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            write_reg_q  <= '0;
        end else begin
            ctrl_wb_q    <= control_wb;
            mem_read_q   <= MemRead;
            mem_write_q  <= MemWrite;
            address_q    <= alu_result;
            write_data_q <= fwd_b;
            write_reg_q  <= write_register;
        end
    end

    assign ex_control_wb     = ctrl_wb_q;
    assign ex_MemRead        = mem_read_q;
    assign ex_MemWrite       = mem_write_q;
    assign ex_address        = address_q;
    assign ex_writeData      = write_data_q;
    assign ex_write_register = write_reg_q;

endmodule
